// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default vectors, BTB index width and
// predictor counter encodings derived from the counter width.
package fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] CTR_STRONG_NT = 32'd0;

    function automatic int unsigned idx_bits(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic logic [31:0] ctr_strong_t(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_weak_t(input int unsigned bits);
        return 32'd1 << (bits - 1);
    endfunction

    function automatic logic [31:0] ctr_weak_nt(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: combinational lookup on one PC,
// registered training from the resolve stage with saturating counters.
module btb_table
    import fetch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int IDX   = int'(idx_bits(BTB_ENTRIES));
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_strong_t(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MIN  = CTR_BITS'(CTR_STRONG_NT);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_weak_t(CTR_BITS));

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0]    ctr_q [BTB_ENTRIES];

    logic [IDX-1:0]   l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    logic [3:0]       unused_pc_lsbs;

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        return (c == CTR_MIN) ? c : c - CTR_BITS'(1);
    endfunction

    assign l_idx = lookup_pc_i[IDX+1:2];
    assign l_tag = lookup_pc_i[XLEN-1:IDX+2];
    assign u_idx = upd_pc_i[IDX+1:2];
    assign u_tag = upd_pc_i[XLEN-1:IDX+2];
    assign unused_pc_lsbs = {lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Lookup reads pre-update contents; no write-to-read bypass.
    assign l_hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pred_taken_o  = l_hit && ctr_q[l_idx][CTR_BITS-1];
    assign pred_target_o = l_hit ? tgt_q[l_idx] : '0;

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (upd_valid_i && !u_hit && upd_taken_i) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (upd_valid_i) begin
            if (u_hit) begin
                if (upd_taken_i) begin
                    ctr_q[u_idx] <= sat_inc(ctr_q[u_idx]);
                    tgt_q[u_idx] <= upd_target_i;
                end else begin
                    ctr_q[u_idx] <= sat_dec(ctr_q[u_idx]);
                end
            end else if (upd_taken_i) begin
                tag_q[u_idx] <= u_tag;
                tgt_q[u_idx] <= upd_target_i;
                ctr_q[u_idx] <= CTR_INIT;
            end
        end
    end

endmodule

// File: rtl/btb_fetch_unit.sv
// IF-stage fetch PC with BTB next-PC prediction, redirects and latched IRQ.
// Optional BTB_STATS_EN adds hit_count / redirect_count outputs.
module btb_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter int              CTR_BITS    = 2,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] IRQ_VEC     = XLEN'(DEF_IRQ_VEC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            irq,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            irq_ack
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     redirect_count
`endif
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            irq_pend_q, irq_pend_d;
    logic            irq_ack_q, irq_ack_d;

    btb_table #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .CTR_BITS    (CTR_BITS)
    ) u_btb (
        .clk_i         (clk),
        .rst_i         (reset),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_valid_i   (update_valid),
        .upd_pc_i      (update_pc),
        .upd_taken_i   (update_taken),
        .upd_target_i  (update_target)
    );

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + XLEN'(4);
    assign irq_ack  = irq_ack_q;

    always_comb begin
        pc_d       = pc_q;
        irq_pend_d = irq_pend_q;
        irq_ack_d  = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (irq) irq_pend_d = 1'b1;
        end else if ((irq_pend_q || irq) && !stall) begin
            pc_d       = IRQ_VEC;
            irq_ack_d  = 1'b1;
            irq_pend_d = 1'b0;
        end else if (stall) begin
            if (irq) irq_pend_d = 1'b1;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            irq_pend_q <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            irq_pend_q <= irq_pend_d;
            irq_ack_q  <= irq_ack_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] hit_cnt_q, redir_cnt_q;
    logic        pred_adv;

    // Mirrors the priority chain: only a prediction-driven advance counts.
    assign pred_adv = !redirect_valid && !stall && !(irq_pend_q || irq) && pred_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q   <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (pred_adv)       hit_cnt_q   <= hit_cnt_q + 32'd1;
            if (redirect_valid) redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end

    assign hit_count      = hit_cnt_q;
    assign redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_btb_fetch_unit.sv
// Scoreboard bench for btb_fetch_unit: directed cycles push expected state,
// a negedge monitor pops and compares.
module tb_btb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        irq = 1'b0;
    logic [31:0] pc, pc_plus4, pred_target;
    logic        pred_taken, irq_ack;
`ifdef BTB_STATS_EN
    logic [31:0] hit_count, redirect_count;
`endif

    btb_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .irq            (irq),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .irq_ack        (irq_ack)
`ifdef BTB_STATS_EN
        ,
        .hit_count      (hit_count),
        .redirect_count (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pt;
        logic [31:0] tgt;
        logic        ack;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (pc !== e.pc || pc_plus4 !== e.pc4 || pred_taken !== e.pt ||
                pred_target !== e.tgt || irq_ack !== e.ack) begin
                fails++;
                $display("FAIL %s: got pc=%h pc4=%h pt=%b tgt=%h ack=%b, want pc=%h pc4=%h pt=%b tgt=%h ack=%b",
                         e.name, pc, pc_plus4, pred_taken, pred_target, irq_ack,
                         e.pc, e.pc4, e.pt, e.tgt, e.ack);
            end
        end
    end

    // One clock edge with the currently driven inputs, then expect the state.
    task automatic step(input string name, input logic [31:0] epc, input logic ept,
                        input logic [31:0] etgt, input logic eack);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = name; e.pc = epc; e.pc4 = epc + 32'd4;
        e.pt = ept; e.tgt = etgt; e.ack = eack;
        sb.push_back(e);
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; update_valid = 1'b0;
        update_taken = 1'b0; irq = 1'b0;
    endtask

    task automatic redir(input logic [31:0] a);
        redirect_valid = 1'b1; redirect_pc = a;
    endtask

    task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tg);
        update_valid = 1'b1; update_pc = a; update_taken = t; update_target = tg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        step("reset", 32'h0, 0, 32'h0, 0);
        step("free1", 32'h4, 0, 32'h0, 0);
        step("free2", 32'h8, 0, 32'h0, 0);
        step("free3", 32'hC, 0, 32'h0, 0);
        step("free4", 32'h10, 0, 32'h0, 0);
        upd(32'h10, 1, 32'h40);
        step("alloc_same_cycle_no_bypass", 32'h14, 0, 32'h0, 0);
        redir(32'h10);
        step("hit_weak_taken", 32'h10, 1, 32'h40, 0);
        step("follow_prediction", 32'h40, 0, 32'h0, 0);
        upd(32'h10, 0, 32'h0);
        step("nt1", 32'h44, 0, 32'h0, 0);
        upd(32'h10, 0, 32'h0);
        step("nt2", 32'h48, 0, 32'h0, 0);
        redir(32'h10);
        step("hit_ctr00", 32'h10, 0, 32'h40, 0);
        step("ctr00_falls_through", 32'h14, 0, 32'h0, 0);
        upd(32'h10, 0, 32'h0); redir(32'h10);
        step("nt3_saturates", 32'h10, 0, 32'h40, 0);
        stall = 1'b1; upd(32'h10, 1, 32'h40);
        step("stall_update_ctr01", 32'h10, 0, 32'h40, 0);
        stall = 1'b1; upd(32'h10, 1, 32'h40);
        step("stall_update_ctr10", 32'h10, 1, 32'h40, 0);
        stall = 1'b1; redir(32'h200);
        step("redirect_over_stall", 32'h200, 0, 32'h0, 0);
        stall = 1'b1; irq = 1'b1;
        step("irq_stall1", 32'h200, 0, 32'h0, 0);
        stall = 1'b1;
        step("irq_stall2", 32'h200, 0, 32'h0, 0);
        stall = 1'b1;
        step("irq_stall3", 32'h200, 0, 32'h0, 0);
        step("irq_service", 32'h8000_0004, 0, 32'h0, 1);
        step("irq_ack_single", 32'h8000_0008, 0, 32'h0, 0);
        redir(32'h10); irq = 1'b1;
        step("redirect_over_irq", 32'h10, 1, 32'h40, 0);
        step("pending_irq_over_pred", 32'h8000_0004, 0, 32'h0, 1);
        step("pending_cleared", 32'h8000_0008, 0, 32'h0, 0);
        upd(32'h50, 1, 32'h100); redir(32'h10);
        step("alias_evicts_0x10", 32'h10, 0, 32'h0, 0);
        redir(32'h50);
        step("alias_0x50_hits", 32'h50, 1, 32'h100, 0);
        step("alias_follow", 32'h100, 0, 32'h0, 0);
        reset = 1'b1; stall = 1'b1; redir(32'h300);
        step("reset_mid_stream", 32'h0, 0, 32'h0, 0);
        redir(32'h50);
        step("reset_clears_0x50", 32'h50, 0, 32'h0, 0);
        redir(32'h10);
        step("reset_clears_0x10", 32'h10, 0, 32'h0, 0);
        redir(32'hFFFF_FFFC);
        step("pc_plus4_wrap", 32'hFFFF_FFFC, 0, 32'h0, 0);
        step("pc_wraps_to_0", 32'h0, 0, 32'h0, 0);
        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
